uart_tx_fifo: RTL

- Byte buffer and pacing stage that sits directly upstream of the high-speed UART transmitter. It feeds that transmitter's uart_send / uart_data_in inputs.
- Producers write bytes at any rate up to one per clock. The block stores them in a circular FIFO and emits one rising edge on uart_send per byte.
- Edges are spaced by a fixed frame time, because the transmitter has no busy/ready feedback. It detects uart_send rising edges through a 2-flop synchroniser and samples uart_data_in about 2 cycles after the edge.

---
 rtl/uart_tx_fifo.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that paces bytes into the UART transmitter, one uart_send
// pulse per byte, with a fixed frame time between pulses.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int FRAME_CLKS  = 260,
    parameter int STROBE_CLKS = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  busy,
    output logic                  uart_send,
    output logic [7:0]            uart_data_in
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [11:0]           STROBE_T = 12'(STROBE_CLKS - 1);
    localparam logic [11:0]           FRAME_T  = 12'(FRAME_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STROBE,
        GAP
    } state_t;

    state_t state_q, state_d;

    logic [11:0]           timer_q, timer_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [7:0]            data_q, data_d;
    logic                  send_q, send_d;
    logic                  ovf_q, ovf_d;
    logic                  full_w, push, pop;
    logic [7:0]            mem [DEPTH];

    // Fullness comes from registered level, so a pop never frees
    // a slot for a write in the same cycle.
    always_comb begin
        full_w   = (level_q == LVL_FULL);
        pop      = (state_q == IDLE) && (level_q != '0);
        push     = wr_en && !full_w;
        ovf_d    = wr_en && full_w;
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                if (pop) state_d = LOAD;
            end
            LOAD: begin
                state_d = STROBE;
                timer_d = '0;
            end
            STROBE: begin
                timer_d = timer_q + 12'd1;
                if (timer_q == STROBE_T) state_d = GAP;
            end
            GAP: begin
                timer_d = timer_q + 12'd1;
                if (timer_q == FRAME_T) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        send_d = (state_d == STROBE);
        data_d = pop ? mem[rd_ptr_q] : data_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
            send_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
            send_q   <= send_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset; level gates every read.
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    assign full         = full_w;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign busy         = (state_q != IDLE);
    assign uart_send    = send_q;
    assign uart_data_in = data_q;

endmodule
